mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Control unit for the multicycle ARM core; drives every control input of the datapath from the instruction register and the ALU flags.
- Contains the main state machine, instruction decode, a condition-code evaluator and the NZCV flag register.
- Consumes Instr and ALUFlags; produces PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc and ALUControl.

Parameters:
FLAGS_RESET, 4'b0000, NZCV value loaded into the flag register on reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears state, flags and condex_q immediately
Instr  input  32  instruction register contents; bits [31:12] used
ALUFlags  input  4  {N,Z,C,V} from ALU, combinational in the current cycle
PCWrite  output  1  PC register enable
MemWrite  output  1  data memory write enable
RegWrite  output  1  register file write enable
IRWrite  output  1  instruction register enable
AdrSrc  output  1  0=PC, 1=Result
RegSrc  output  2  [0]=1 reads R15 on RA1; [1]=1 reads Rd on RA2
ALUSrcA  output  2  00=A, 01=PC
ALUSrcB  output  2  00=WriteData, 01=ExtImm, 10=constant 4
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ImmSrc  output  2  00=imm8 (DP), 01=imm12 (mem), 10=imm24 (branch)
ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR
State  output  4  current FSM state encoding, for debug

Behaviour:
- Field decode: op=Instr[27:26], funct=Instr[25:20], cond=Instr[31:28], Rd=Instr[15:12], cmd=Instr[24:21], S=Instr[20], I=Instr[25], L=Instr[20], U=Instr[23].
- States, encoded 0-9: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE: op=00 -> EXECUTEI if I, else EXECUTER; op=01 -> MEMADR; op=10 -> BRANCH; op=11 -> FETCH (undefined op, treated as NOP).
  - MEMADR -> MEMREAD if L, else MEMWRITE.
  - MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH.
  - EXECUTER/EXECUTEI->ALUWB->FETCH; BRANCH->FETCH.
- Instruction latency: DP 4 cycles, LDR 5, STR 4, B 3.
- Outputs are Moore-style: decoded from State and Instr only, never from ALUFlags directly. Any output not listed below for a state is 0.
- Static, all states: RegSrc={op==01 & ~L, op==10}; ImmSrc=op (op=11 gives 00).
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite=1 (unconditional).
- DECODE: ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=10. condex_q <= CondEx(cond, flags) at the end of this cycle.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl = U ? 000 : 001.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=condex_q.
- MEMWB: ResultSrc=01, RegWrite=condex_q, PCWrite=condex_q & (Rd==15).
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUControl from cmd.
- EXECUTEI: same as EXECUTER except ALUSrcB=01.
- cmd decode:
  - 0100 ADD -> 000; 0010 SUB -> 001; 0000 AND -> 010; 1100 ORR -> 011.
  - 1010 CMP -> 001, with no register write and S forced to 1.
  - Any other cmd -> 000 with no register write and no flag write.
- Flag write, at the end of EXECUTER/EXECUTEI only, when condex_q & S_eff (S_eff = S, or 1 for CMP):
  - N,Z <= ALUFlags[3:2] for all supported cmds.
  - C,V <= ALUFlags[1:0] only for ADD, SUB and CMP; AND and ORR preserve C,V.
- ALUWB: ResultSrc=00, RegWrite=condex_q & writable(cmd), PCWrite=condex_q & writable(cmd) & (Rd==15).
- BRANCH: ALUSrcA=00 (A holds R15 read in DECODE), ALUSrcB=01, ALUControl=000, ResultSrc=10, PCWrite=condex_q. BL is executed as B (no link).
- CondEx: full ARM table for codes 0000-1110 (EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL); 1111 evaluates false.
- condex_q is latched once per instruction. A flag update in EXECUTE does not affect the same instruction's writeback.
- Reset:
  - While reset is high: State=FETCH, flags=FLAGS_RESET, condex_q=0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0; the other outputs show FETCH values.
  - A reset mid-instruction abandons it; no write enable pulses afterwards.
  - The first FETCH is the first rising edge after reset deasserts.

Test Plan:
1. Reset held 3 cycles, then released; Instr=0xE0812003 (ADD R2,R1,R3) -> State 0,1,6,8,0. ALUWB has RegWrite=1, ResultSrc=00, ALUControl=000 during EXECUTER. All enables stay 0 during reset.
2. Instr=0xE2510005 (SUBS R0,R1,#5), ALUFlags=4'b0110 in EXECUTEI -> flags=0110 afterwards. Next instr 0x0A000002 (BEQ) -> BRANCH has PCWrite=1. Repeat with ALUFlags=0000 -> BRANCH has PCWrite=0; IRWrite still pulses in the next FETCH.
3. Instr=0xE5912004 (LDR R2,[R1,#4]) -> states 0,1,2,3,4. ALUControl=000 and ImmSrc=01 in MEMADR; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB. 5-cycle latency.
4. Instr=0xE5012004 (STR, U=0) -> ALUControl=001 in MEMADR; MEMWRITE has MemWrite=1, RegSrc=2'b10. Same instruction with cond=0000 and Z=0 -> MemWrite=0.
5. Instr=0xE1510002 (CMP R1,R2), then 0xE0000002 (AND, S=0) -> CMP: ALUWB RegWrite=0, flags updated. AND: flags unchanged, C,V preserved. Instr=0xEC000000 (op=11) -> FETCH, DECODE, FETCH with no writes.
6. Assert reset asynchronously during MEMWRITE -> MemWrite drops to 0 in the same cycle, State=0, flags=FLAGS_RESET. Instr=0xE081F003 (ADD PC,R1,R3) -> ALUWB has PCWrite=1 and RegWrite=1.

Source files
------------

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_unit
// Description : Control unit for the multicycle ARM core. Holds the main FSM,
//               instruction decode, condition-code evaluator and the NZCV
//               flag register, and drives every datapath control input.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_unit #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  flags_q, flags_d;
    logic        condex_q, condex_d;

    // Instruction fields
    logic [1:0]  w_op;
    logic [3:0]  w_cond;
    logic [3:0]  w_rd;
    logic [3:0]  w_cmd;
    logic        w_s, w_i, w_l, w_u;
    logic        w_rd_pc;

    assign w_op    = Instr[27:26];
    assign w_cond  = Instr[31:28];
    assign w_rd    = Instr[15:12];
    assign w_cmd   = Instr[24:21];
    assign w_s     = Instr[20];
    assign w_i     = Instr[25];
    assign w_l     = Instr[20];
    assign w_u     = Instr[23];
    assign w_rd_pc = (w_rd == 4'd15);

    // Rn and the immediate/shift fields are consumed by the datapath only
    logic w_unused;
    assign w_unused = ^{Instr[19:16], Instr[11:0]};

    // ARM condition evaluation against {N,Z,C,V}; code 1111 never executes
    function automatic logic cond_ex(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = cf;
            4'b0011: cond_ex = ~cf;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = cf & ~z;
            4'b1001: cond_ex = ~cf | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    endfunction

    // Data-processing command decode: ALU op, register writeback, flag writes
    logic [2:0] w_alu_dp;
    logic       w_writable;
    logic       w_flag_we;
    logic       w_cv_we;

    // Map cmd to ALU operation and which architectural state it may update
    always_comb begin
        w_alu_dp   = 3'b000;
        w_writable = 1'b0;
        w_flag_we  = 1'b0;
        w_cv_we    = 1'b0;
        case (w_cmd)
            4'b0100: begin w_alu_dp = 3'b000; w_writable = 1'b1; w_flag_we = w_s;  w_cv_we = 1'b1; end
            4'b0010: begin w_alu_dp = 3'b001; w_writable = 1'b1; w_flag_we = w_s;  w_cv_we = 1'b1; end
            4'b0000: begin w_alu_dp = 3'b010; w_writable = 1'b1; w_flag_we = w_s;  w_cv_we = 1'b0; end
            4'b1100: begin w_alu_dp = 3'b011; w_writable = 1'b1; w_flag_we = w_s;  w_cv_we = 1'b0; end
            4'b1010: begin w_alu_dp = 3'b001; w_writable = 1'b0; w_flag_we = 1'b1; w_cv_we = 1'b1; end
            default: begin w_alu_dp = 3'b000; w_writable = 1'b0; w_flag_we = 1'b0; w_cv_we = 1'b0; end
        endcase
    end

    // State, flag and condition registers; reset abandons any instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            flags_q  <= FLAGS_RESET;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    // Next state, condition latch in DECODE, flag update at end of EXECUTE
    always_comb begin
        state_d  = state_q;
        condex_d = condex_q;
        flags_d  = flags_q;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                condex_d = cond_ex(w_cond, flags_q);
                case (w_op)
                    2'b00:   state_d = w_i ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = w_l ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECUTER, EXECUTEI: begin
                state_d = ALUWB;
                if (condex_q && w_flag_we) begin
                    flags_d[3:2] = ALUFlags[3:2];
                    if (w_cv_we) begin
                        flags_d[1:0] = ALUFlags[1:0];
                    end
                end
            end
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    logic w_pcw, w_mw, w_rw, w_irw;

    // Moore output decode from state and instruction
    always_comb begin
        w_pcw      = 1'b0;
        w_mw       = 1'b0;
        w_rw       = 1'b0;
        w_irw      = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        RegSrc     = {(w_op == 2'b01) & ~w_l, (w_op == 2'b10)};
        ImmSrc     = (w_op == 2'b11) ? 2'b00 : w_op;
        case (state_q)
            FETCH: begin
                w_irw     = 1'b1;
                w_pcw     = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_u ? 3'b000 : 3'b001;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                w_mw   = condex_q;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                w_rw      = condex_q;
                w_pcw     = condex_q & w_rd_pc;
            end
            EXECUTER: begin
                ALUControl = w_alu_dp;
            end
            EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_dp;
            end
            ALUWB: begin
                w_rw  = condex_q & w_writable;
                w_pcw = condex_q & w_writable & w_rd_pc;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcw     = condex_q;
            end
            default: ;
        endcase
    end

    // Write enables are held off for as long as reset is asserted
    assign PCWrite  = w_pcw & ~reset;
    assign MemWrite = w_mw  & ~reset;
    assign RegWrite = w_rw  & ~reset;
    assign IRWrite  = w_irw & ~reset;
    assign State    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_unit
// Description : Scoreboard bench for mc_control_unit. Stimulus pushes the
//               hand-computed per-cycle control vector; a monitor pops and
//               compares it against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_unit;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;

    mc_control_unit #(.FLAGS_RESET(4'b0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, mw, rw, irw, adr;
        logic [1:0] regsrc, srca, srcb, res, imm;
        logic [2:0] alu;
    } vec_t;

    typedef struct {
        vec_t  v;
        string name;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    event  mid_ev;

    logic [1:0] g_regsrc;
    logic [1:0] g_imm;

    localparam logic [3:0] ALUF_IDLE = 4'b1001;

    // Monitor: compare DUT against the oldest expectation at each sample point
    initial begin
        item_t it;
        vec_t  act;
        forever begin
            @(negedge clk or mid_ev);
            if (q.size() > 0) begin
                it  = q.pop_front();
                act = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                       RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
                n_cmp++;
                if (act !== it.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h (st=%0d pcw=%b mw=%b rw=%b irw=%b) expected %h (st=%0d pcw=%b mw=%b rw=%b irw=%b)",
                             it.name, act, act.st, act.pcw, act.mw, act.rw, act.irw,
                             it.v, it.v.st, it.v.pcw, it.v.mw, it.v.rw, it.v.irw);
                end
            end
        end
    end

    function automatic vec_t mk(input logic [3:0] st, input logic pcw, input logic mw,
                                input logic rw, input logic irw, input logic adr,
                                input logic [1:0] srca, input logic [1:0] srcb,
                                input logic [1:0] res, input logic [2:0] alu);
        vec_t v;
        v = {st, pcw, mw, rw, irw, adr, g_regsrc, srca, srcb, res, g_imm, alu};
        return v;
    endfunction

    // Push the expectation for the current cycle, then advance one cycle
    task automatic step(input string name, input vec_t v);
        item_t it;
        it.v    = v;
        it.name = name;
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] ins, input logic [1:0] rs, input logic [1:0] im);
        Instr    = ins;
        g_regsrc = rs;
        g_imm    = im;
    endtask

    task automatic fetch_decode(input string name);
        step({name, ".fetch"},  mk(4'd0, 1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 3'b000));
        step({name, ".decode"}, mk(4'd1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'b000));
    endtask

    task automatic do_dp(input string name, input logic [31:0] ins, input logic imm_form,
                         input logic [2:0] alu, input logic [3:0] exflags,
                         input logic rw, input logic pcw);
        set_instr(ins, 2'b00, 2'b00);
        fetch_decode(name);
        ALUFlags = exflags;
        if (imm_form)
            step({name, ".execi"}, mk(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, alu));
        else
            step({name, ".execr"}, mk(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, alu));
        ALUFlags = ALUF_IDLE;
        step({name, ".aluwb"}, mk(4'd8, pcw, 0, rw, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
    endtask

    task automatic do_ldr(input string name, input logic [31:0] ins, input logic [2:0] alu,
                          input logic rw, input logic pcw);
        set_instr(ins, 2'b00, 2'b01);
        fetch_decode(name);
        step({name, ".memadr"},  mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, alu));
        step({name, ".memread"}, mk(4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000));
        step({name, ".memwb"},   mk(4'd4, pcw, 0, rw, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000));
    endtask

    task automatic do_str(input string name, input logic [31:0] ins, input logic [2:0] alu,
                          input logic mw);
        set_instr(ins, 2'b10, 2'b01);
        fetch_decode(name);
        step({name, ".memadr"},   mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, alu));
        step({name, ".memwrite"}, mk(4'd5, 0, mw, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000));
    endtask

    task automatic do_b(input string name, input logic [31:0] ins, input logic pcw);
        set_instr(ins, 2'b01, 2'b10);
        fetch_decode(name);
        step({name, ".branch"}, mk(4'd9, pcw, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000));
    endtask

    // Directed stimulus
    initial begin
        reset    = 1'b1;
        ALUFlags = ALUF_IDLE;
        set_instr(32'hE0812003, 2'b00, 2'b00);
        @(posedge clk);
        #1;
        // Reset held: FETCH routing visible, all enables low
        for (int i = 0; i < 3; i++)
            step("reset_hold", mk(4'd0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'b000));
        reset = 1'b0;

        // ADD R2,R1,R3
        do_dp("add", 32'hE0812003, 1'b0, 3'b000, 4'b1111, 1'b1, 1'b0);
        // SUBS R0,R1,#5 -> flags 0110, BEQ taken
        do_dp("subs_z", 32'hE2510005, 1'b1, 3'b001, 4'b0110, 1'b1, 1'b0);
        do_b("beq_taken", 32'h0A000002, 1'b1);
        // SUBS -> flags 0000, BEQ not taken
        do_dp("subs_nz", 32'hE2510005, 1'b1, 3'b001, 4'b0000, 1'b1, 1'b0);
        do_b("beq_not", 32'h0A000002, 1'b0);
        // LDR R2,[R1,#4]
        do_ldr("ldr", 32'hE5912004, 3'b000, 1'b1, 1'b0);
        // STR with U=0, then conditional EQ with Z=0
        do_str("str", 32'hE5012004, 3'b001, 1'b1);
        do_str("streq_not", 32'h05012004, 3'b001, 1'b0);
        // CMP: no writeback, flags <- 0011; BVS taken
        do_dp("cmp", 32'hE1510002, 1'b0, 3'b001, 4'b0011, 1'b0, 1'b0);
        do_b("bvs_after_cmp", 32'h6A000002, 1'b1);
        // AND with S=0 leaves flags at 0011
        do_dp("and", 32'hE0000002, 1'b0, 3'b010, 4'b1100, 1'b1, 1'b0);
        do_b("beq_after_and", 32'h0A000002, 1'b0);
        do_b("bvs_after_and", 32'h6A000002, 1'b1);
        // ANDS: N,Z from ALU (Z=1), C,V kept at 1 -> 0111
        do_dp("ands", 32'hE0100002, 1'b0, 3'b010, 4'b0100, 1'b1, 1'b0);
        // EORS (unsupported): no writeback, no flag write
        do_dp("eors", 32'hE0310002, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);
        do_b("beq_after_ands", 32'h0A000002, 1'b1);
        do_b("bcs_after_ands", 32'h2A000002, 1'b1);
        // Undefined op=11 behaves as a two-cycle NOP
        set_instr(32'hEC000000, 2'b00, 2'b00);
        fetch_decode("undef");

        // STR interrupted by asynchronous reset during MEMWRITE
        set_instr(32'hE5012004, 2'b10, 2'b01);
        fetch_decode("str_rst");
        step("str_rst.memadr", mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3'b001));
        begin
            item_t it;
            it.v    = mk(4'd5, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000);
            it.name = "str_rst.memwrite";
            q.push_back(it);
            #5;
            reset = 1'b1;
            #1;
            it.v    = mk(4'd0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'b000);
            it.name = "str_rst.async";
            q.push_back(it);
            ->mid_ev;
            @(posedge clk);
            #1;
        end
        step("str_rst.hold", mk(4'd0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'b000));
        reset = 1'b0;
        // Flags back to FLAGS_RESET=0000: EQ false, NE true
        do_b("beq_after_rst", 32'h0A000002, 1'b0);
        do_b("bne_after_rst", 32'h1A000002, 1'b1);
        // ADD PC,R1,R3 writes PC and register
        do_dp("add_pc", 32'hE081F003, 1'b0, 3'b000, 4'b1111, 1'b1, 1'b1);

        repeat (2) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
